// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DZ   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SUB_CHUNK = 4;

  // Counter must hold WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divide unit.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_div_sub_stage.sv
// (WIDTH+1)-bit trial subtractor: i_rp - {0,i_divisor} as a chain of 4-bit
// ripple-carry adders fed with the inverted divisor and carry-in 1.
module div_rca4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  always_comb begin
    w_c[0] = i_cin;
    o_sum  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end
endmodule

module div_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rp,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_diff,
  output logic             o_no_borrow
);
  localparam int NCH = WIDTH / SUB_CHUNK + 1;
  localparam int EW  = NCH * SUB_CHUNK;

  logic [EW-1:0] w_a;
  logic [EW-1:0] w_b_n;
  logic [EW-1:0] w_sum;
  logic [NCH:0]  w_c;
  logic          w_unused_sum;

  // Zero-extend both operands to a whole number of chunks; the final carry-out
  // is then the borrow-free flag of the (WIDTH+1)-bit subtract.
  assign w_a    = EW'(i_rp);
  assign w_b_n  = ~(EW'(i_divisor));
  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    div_rca4 u_rca4 (
      .i_a    (w_a[g*SUB_CHUNK +: SUB_CHUNK]),
      .i_b    (w_b_n[g*SUB_CHUNK +: SUB_CHUNK]),
      .i_cin  (w_c[g]),
      .o_sum  (w_sum[g*SUB_CHUNK +: SUB_CHUNK]),
      .o_cout (w_c[g + 1])
    );
  end

  assign o_diff       = w_sum[WIDTH:0];
  assign o_no_borrow  = w_c[NCH];
  assign w_unused_sum = ^w_sum[EW-1:WIDTH+1];
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | WIDTH shift/subtract steps
//   S_DZ   | divisor was zero, one-cycle bypass
//   S_DONE | results valid, done pulse
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  logic [WIDTH:0]   w_rp;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_no_borrow;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_unused_msb;

  assign w_rp = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .i_rp        (w_rp),
    .i_divisor   (r_div),
    .o_diff      (w_diff),
    .o_no_borrow (w_no_borrow)
  );

  assign w_rem_nxt    = w_no_borrow ? w_diff : w_rp;
  assign w_q_nxt      = {r_q[WIDTH-2:0], w_no_borrow};
  assign w_last       = (r_cnt == CW'(1));
  assign w_accept     = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_unused_msb = r_rem[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (bus.divisor == '0) ? S_DZ : S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DZ: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (w_accept) w_next = (bus.divisor == '0) ? S_DZ : S_RUN;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_q doubles as the captured dividend, which the DZ path reports unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_q   <= bus.dividend;
      r_div <= bus.divisor;
      r_cnt <= CW'(WIDTH);
      r_dz  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_remo <= w_rem_nxt[WIDTH-1:0];
      end
    end else if (r_state == S_DZ) begin
      r_quot <= '1;
      r_remo <= r_q;
      r_dz   <= 1'b1;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed WIDTH=32 scenarios and a WIDTH=8 random sweep.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst32;
  logic rst8;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) if32 ();
  seq_divider_if #(.WIDTH(8))  if8 ();

  seq_divider #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst32), .bus(if32));
  seq_divider #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(if8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, output int c0);
    c0            = cyc;
    if32.start    = 1'b1;
    if32.dividend = a;
    if32.divisor  = b;
    tick();
    if32.start    = 1'b0;
  endtask

  task automatic expect32(input string tag, input int c0, input logic [31:0] q,
                          input logic [31:0] r, input logic dz, input int lat_exp);
    int busy_low;
    busy_low = 0;
    while (!if32.done && (cyc - c0) < 100) begin
      if (!if32.busy) busy_low++;
      tick();
    end
    chk({tag, "_latency"}, 64'(cyc - c0), 64'(lat_exp));
    chk({tag, "_busy_gap"}, 64'(busy_low), 64'(0));
    chk({tag, "_quotient"}, 64'(if32.quotient), 64'(q));
    chk({tag, "_remainder"}, 64'(if32.remainder), 64'(r));
    chk({tag, "_dz"}, 64'(if32.div_by_zero), 64'(dz));
  endtask

  initial begin
    int c0;
    int seen;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] qe;
    logic [7:0] re;
    int lat_e;
    int junk_at;
    int busy_low;

    rst32 = 1'b1;
    rst8  = 1'b1;
    if32.start = 1'b0; if32.dividend = '0; if32.divisor = '0;
    if8.start  = 1'b0; if8.dividend  = '0; if8.divisor  = '0;
    tick();
    tick();
    chk("rst_busy", 64'(if32.busy), 64'(0));
    chk("rst_done", 64'(if32.done), 64'(0));
    chk("rst_quotient", 64'(if32.quotient), 64'(0));
    chk("rst_remainder", 64'(if32.remainder), 64'(0));
    chk("rst_dz", 64'(if32.div_by_zero), 64'(0));
    rst32 = 1'b0;
    rst8  = 1'b0;
    tick();

    // 100 / 7
    start32(32'd100, 32'd7, c0);
    chk("t1_busy_c1", 64'(if32.busy), 64'(1));
    expect32("t1", c0, 32'd14, 32'd2, 1'b0, 33);
    tick();
    chk("t1_done_single", 64'(if32.done), 64'(0));
    chk("t1_idle_busy", 64'(if32.busy), 64'(0));
    chk("t1_hold_q", 64'(if32.quotient), 64'(14));

    // all-ones / 1, then back-to-back 3 / 10 from the DONE cycle
    start32(32'hFFFF_FFFF, 32'd1, c0);
    expect32("t2", c0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    start32(32'd3, 32'd10, c0);
    chk("t2_b2b_busy", 64'(if32.busy), 64'(1));
    chk("t2_b2b_done", 64'(if32.done), 64'(0));
    expect32("t2b", c0, 32'd0, 32'd3, 1'b0, 33);
    tick();

    // divide by zero, then a normal op clears the flag
    start32(32'd5, 32'd0, c0);
    expect32("t3", c0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    tick();
    chk("t3_dz_hold", 64'(if32.div_by_zero), 64'(1));
    start32(32'd9, 32'd3, c0);
    chk("t3_dz_clear", 64'(if32.div_by_zero), 64'(0));
    expect32("t3b", c0, 32'd3, 32'd0, 1'b0, 33);
    tick();

    // start while busy is ignored
    start32(32'd1000, 32'd9, c0);
    while ((cyc - c0) < 10) tick();
    if32.start = 1'b1; if32.dividend = 32'd50; if32.divisor = 32'd5;
    tick();
    if32.start = 1'b0;
    expect32("t4", c0, 32'd111, 32'd1, 1'b0, 33);
    tick();

    // reset mid-operation discards it
    start32(32'd1000, 32'd9, c0);
    while ((cyc - c0) < 15) tick();
    rst32 = 1'b1;
    tick();
    rst32 = 1'b0;
    chk("t5_rst_busy", 64'(if32.busy), 64'(0));
    chk("t5_rst_quotient", 64'(if32.quotient), 64'(0));
    chk("t5_rst_remainder", 64'(if32.remainder), 64'(0));
    seen = 0;
    repeat (40) begin
      if (if32.done) seen++;
      tick();
    end
    chk("t5_no_done", 64'(seen), 64'(0));
    start32(32'd8, 32'd2, c0);
    expect32("t5b", c0, 32'd4, 32'd0, 1'b0, 33);

    // WIDTH=8 random sweep against plain arithmetic
    for (int i = 0; i < 2000; i++) begin
      a8 = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       b8 = 8'd0;
        1:       b8 = 8'd1;
        2:       begin a8 = 8'hFF; b8 = 8'hFF; end
        3:       b8 = (a8 == 8'hFF) ? 8'hFF : 8'($urandom_range(int'(a8) + 1, 255));
        default: b8 = 8'($urandom_range(1, 255));
      endcase
      if (b8 == 8'd0) begin
        qe = 8'hFF; re = a8; lat_e = 2;
      end else begin
        qe = a8 / b8; re = a8 % b8; lat_e = 9;
      end
      repeat ($urandom_range(0, 2)) tick();
      c0 = cyc;
      if8.start = 1'b1; if8.dividend = a8; if8.divisor = b8;
      tick();
      if8.start = 1'b0;
      junk_at  = $urandom_range(1, 12);
      busy_low = 0;
      while (!if8.done && (cyc - c0) < 50) begin
        if (!if8.busy) busy_low++;
        if (if8.busy && (cyc - c0) == junk_at) begin
          if8.start    = 1'b1;
          if8.dividend = 8'($urandom_range(0, 255));
          if8.divisor  = 8'($urandom_range(0, 255));
        end
        tick();
        if8.start = 1'b0;
      end
      chk("sw_latency", 64'(cyc - c0), 64'(lat_e));
      chk("sw_busy_gap", 64'(busy_low), 64'(0));
      chk("sw_quotient", 64'(if8.quotient), 64'(qe));
      chk("sw_remainder", 64'(if8.remainder), 64'(re));
      chk("sw_dz", 64'(if8.div_by_zero), 64'(b8 == 8'd0));
      if (b8 != 8'd0)
        chk("sw_identity",
            64'((32'(if8.quotient) * 32'(b8) + 32'(if8.remainder) == 32'(a8)) &&
                (if8.remainder < b8)),
            64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider: the inverse operation to the multiplier datapath. Produces one quotient bit per clock.
- Each trial subtraction is a (WIDTH+1)-bit subtract. It is built as a ripple-carry add of the inverted divisor with carry-in 1.
- Sits beside the multiplier as the divide unit. Uses a start/busy/done handshake toward the issuing controller.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are multiples of 4, from 4 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only when busy=0
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- Reset: synchronous, active-high, on the clk rising edge only.
  - State returns to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - rst has priority over every other event, including mid-operation: the in-flight operation is discarded and no done is issued.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DZ: one-cycle divide-by-zero path, busy=1.
  - DONE: busy=0, done=1.
- Accept rule: start is accepted in IDLE or DONE when it is sampled at a rising edge E0.
  - Operands are captured into internal registers.
  - The partial remainder register (WIDTH+1 bits) clears to 0.
  - The quotient shift register loads the dividend.
  - The counter loads WIDTH.
  - Next state is RUN, or DZ if divisor==0.
- start while busy=1 is ignored; the operation in flight is unaffected.
- RUN step, once per edge:
  - r' = {r[WIDTH-1:0], q[WIDTH-1]}; trial t = r' - {0,divisor}.
  - If t is non-negative (subtract carry-out=1): r <= t, shift 1 into the q LSB.
  - Otherwise: r <= r', shift 0 into the q LSB.
  - Counter decrements. On the step where counter==1, the final values go to quotient/remainder and next state is DONE.
- Latency: start sampled in cycle 0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1 only.
- DZ path: start in cycle 0 → busy high in cycle 1 → done=1 in cycle 2, with:
  - quotient = all ones
  - remainder = dividend
  - div_by_zero = 1
- Outputs hold:
  - quotient, remainder and div_by_zero hold their values after done until the next accepted start.
  - div_by_zero clears on the next accepted start.
  - quotient/remainder are not updated during RUN; the working copy is internal.
- DONE → IDLE next cycle unless start is accepted in DONE. A back-to-back start in the DONE cycle goes straight to RUN/DZ.
- Boundaries:
  - dividend < divisor → quotient 0, remainder = dividend.
  - dividend == 0 → 0/0 (unless divisor 0).
  - divisor 1 → quotient = dividend, remainder 0.
  - All-ones/all-ones → 1/0.
  - Remainder is always < divisor when div_by_zero=0.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DZ, DONE) and a WIDTH-dependent counter width constant, clog2(WIDTH+1).
- Sub-module: div_sub_stage.
  - Combinational (WIDTH+1)-bit trial subtractor: inputs r', divisor; outputs difference and no_borrow.
  - Built by chaining 4-bit ripple-carry adders on the inverted divisor with cin=1.
  - Reusable by the multiplier's final adder tree.
- Top level holds the FSM, counter and shift registers.

Test Plan (WIDTH=32 unless stated):
- dividend=100, divisor=7, start cycle 0 → busy cycles 1–32; done only in cycle 33; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then 3/10 started in the DONE cycle → busy the next cycle, quotient=0, remainder=3 at its done.
- dividend=5, divisor=0 → done in cycle 2; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Next accepted start (e.g. 9/3) clears div_by_zero; result is 3/0.
- start 1000/9, then start pulsed again with 50/5 in cycle 10 → second request ignored; done in cycle 33 with quotient=111, remainder=1.
- start 1000/9, assert rst in cycle 15 → next cycle busy=0, quotient=0, remainder=0; no done pulse ever appears. A fresh 8/2 then completes normally with quotient=4.
- WIDTH=8 random sweep of 2000 operand pairs vs reference model → quotient*divisor+remainder==dividend, remainder<divisor; done always in cycle 9 after start.
